// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter giving several packet sources one UART transmitter
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int TX_TIMEOUT   = 8192,
   parameter int HOLD_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_done_tick,
   output logic                 busy,
   output logic [1:0]           grant_id,
   output logic                 tx_err,
   output logic                 hold_err
);

   localparam int MAX_TO = (TX_TIMEOUT > HOLD_TIMEOUT) ? TX_TIMEOUT : HOLD_TIMEOUT;
   localparam int CW     = $clog2(MAX_TO + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t           r_state;
   logic [1:0]       r_rr_ptr;
   logic [1:0]       r_grant;
   logic [7:0]       r_tx_data;
   logic             r_tx_start;
   logic             r_last;
   logic             r_tx_err;
   logic             r_hold_err;
   logic [CW-1:0]    r_cnt;

   logic [1:0]         w_idx;
   logic [1:0]         w_win;
   logic               w_win_vld;
   logic [1:0]         w_sel;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_fire;

   // Scan from farthest to nearest so the requester closest after rr_ptr is the last one written.
   always_comb begin
      w_idx     = '0;
      w_win     = '0;
      w_win_vld = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = 2'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (req_valid[w_idx]) begin
            w_win     = w_idx;
            w_win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (reset) begin
         case (r_state)
            S_IDLE:  if (w_win_vld) w_ready[w_win] = 1'b1;
            S_HOLD:  w_ready[r_grant] = 1'b1;
            default: w_ready = '0;
         endcase
      end
   end

   assign w_sel  = (r_state == S_HOLD) ? r_grant : w_win;
   assign w_fire = |(w_ready & req_valid);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 2'(NUM_REQ - 1);
         r_grant    <= '0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_last     <= 1'b0;
         r_tx_err   <= 1'b0;
         r_hold_err <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_tx_err   <= 1'b0;
         r_hold_err <= 1'b0;
         // A transfer outranks a HOLD expiry in the same cycle.
         if (w_fire) begin
            r_tx_data  <= req_data[8*w_sel +: 8];
            r_last     <= req_last[w_sel];
            r_grant    <= w_sel;
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT;
            r_cnt      <= '0;
         end else begin
            case (r_state)
               S_WAIT: begin
                  if (tx_done_tick) begin
                     if (r_last) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= r_grant;
                     end else begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                     end
                  end else if (r_cnt == CW'(TX_TIMEOUT - 1)) begin
                     r_tx_err <= 1'b1;
                     r_state  <= S_IDLE;
                     r_rr_ptr <= r_grant;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_HOLD: begin
                  if (r_cnt == CW'(HOLD_TIMEOUT - 1)) begin
                     r_hold_err <= 1'b1;
                     r_state    <= S_IDLE;
                     r_rr_ptr   <= r_grant;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign req_ready = w_ready;
   assign tx_start  = r_tx_start;
   assign tx_data   = r_tx_data;
   assign busy      = (r_state != S_IDLE);
   assign grant_id  = r_grant;
   assign tx_err    = r_tx_err;
   assign hold_err  = r_hold_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done_tick;
   logic        busy;
   logic [1:0]  grant_id;
   logic        tx_err;
   logic        hold_err;

   logic auto_pulse = 1'b0;
   logic man_done = 1'b0;
   logic auto_done = 1'b1;
   assign tx_done_tick = auto_pulse | man_done;

   int n_tests = 0;
   int n_fail = 0;
   int n_start = 0;
   int n_txerr = 0;
   int n_holderr = 0;
   int dcnt = 0;

   logic [9:0] exp_q[$];
   logic [8:0] rq[NR][$];
   logic [3:0] fire = '0;

   uart_tx_arbiter #(.NUM_REQ(4), .TX_TIMEOUT(8192), .HOLD_TIMEOUT(1024)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
      .tx_data(tx_data), .tx_done_tick(tx_done_tick), .busy(busy),
      .grant_id(grant_id), .tx_err(tx_err), .hold_err(hold_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input int id, input logic last, input logic [7:0] b, input logic expect_tx);
      rq[id].push_back({last, b});
      if (expect_tx) exp_q.push_back({2'(id), b});
   endtask

   // Requester models: retire a byte after valid&ready, then present the next one.
   always @(negedge clk) begin
      for (int i = 0; i < NR; i++)
         if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      #1;
      fire = req_valid & req_ready;
   end

   // Transmitter model: done tick 10 cycles after each start.
   always @(negedge clk) begin
      auto_pulse = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) auto_pulse = 1'b1;
      end
      if (tx_start && auto_done) dcnt = 10;
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      logic [9:0] e;
      if (tx_start) begin
         n_start++;
         if (exp_q.size() == 0) begin
            chk("unexpected_tx_start", {22'd0, grant_id, tx_data}, 32'h3ff);
         end else begin
            e = exp_q.pop_front();
            chk("sb_grant_id", grant_id, e[9:8]);
            chk("sb_tx_data", tx_data, e[7:0]);
            chk("sb_busy", busy, 1);
         end
      end
      if (tx_err) n_txerr++;
      if (hold_err) n_holderr++;
   end

   function automatic bit pending();
      bit p = (exp_q.size() != 0) || busy;
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_drain(input int budget, input string name);
      int c = 0;
      while (pending() && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(name, c < budget, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start(input int budget, input string name);
      int c = 0;
      @(negedge clk);
      while (!tx_start && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(name, c < budget, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_grant"}, grant_id, 0);
      chk({tag, "_tx_data"}, tx_data, 8'h00);
      chk({tag, "_tx_start"}, tx_start, 0);
      chk({tag, "_tx_err"}, tx_err, 0);
      chk({tag, "_hold_err"}, hold_err, 0);
      chk({tag, "_ready"}, req_ready, 4'b0000);
   endtask

   initial begin
      int c, hc, e0, n0;
      bit pushed;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;

      // Round robin of single-byte packets from all four requesters.
      send(0, 1'b1, 8'h55, 1'b1);
      send(1, 1'b1, 8'hAA, 1'b1);
      send(2, 1'b1, 8'h0F, 1'b1);
      send(3, 1'b1, 8'hF0, 1'b1);
      wait_drain(300, "rr_drain");
      chk("rr_start_count", n_start, 4);

      // Multi-byte packet from 2 must not be interleaved with 0/1.
      send(2, 1'b0, 8'h11, 1'b1);
      send(2, 1'b0, 8'h22, 1'b1);
      send(2, 1'b1, 8'h33, 1'b1);
      c = 0;
      while (!busy && c < 20) begin @(negedge clk); c++; end
      chk("pkt_busy", c < 20, 1);
      send(0, 1'b1, 8'h44, 1'b1);
      send(1, 1'b1, 8'h66, 1'b1);
      wait_drain(400, "pkt_drain");

      // Packet left open by requester 1 -> HOLD expiry; stray done in HOLD.
      send(1, 1'b0, 8'hA5, 1'b1);
      c = 0;
      while (!(busy && req_ready == 4'b0010) && c < 100) begin @(negedge clk); c++; end
      chk("hold_entered", c < 100, 1);
      hc = 1; c = 0; pushed = 1'b0;
      while (c < 1200) begin
         @(negedge clk);
         c++;
         man_done = 1'b0;
         if (hold_err) break;
         if (busy && req_ready == 4'b0010) hc++;
         if (hc == 100) man_done = 1'b1;
         if (hc == 200 && !pushed) begin
            send(3, 1'b1, 8'h3C, 1'b1);
            pushed = 1'b1;
         end
      end
      man_done = 1'b0;
      chk("hold_err_seen", hold_err, 1);
      chk("hold_cycles", hc, 1024);
      chk("hold_exit_idle", busy, 0);
      @(negedge clk);
      chk("hold_err_one_cycle", hold_err, 0);
      wait_drain(200, "hold_drain");
      chk("hold_err_count", n_holderr, 1);

      // TX timeout with no done tick.
      auto_done = 1'b0;
      send(0, 1'b1, 8'h77, 1'b1);
      wait_start(50, "to_start");
      c = 0;
      while (!tx_err && c < 9000) begin @(negedge clk); c++; end
      chk("tx_timeout_cycles", c, 8192);
      chk("tx_timeout_idle", busy, 0);
      @(negedge clk);
      chk("tx_timeout_idle_next", busy, 0);
      chk("tx_err_one_cycle", tx_err, 0);

      // Done tick on the expiry cycle counts as done.
      e0 = n_txerr;
      send(0, 1'b1, 8'h78, 1'b1);
      wait_start(50, "edge_start");
      repeat (8191) @(negedge clk);
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      chk("edge_done_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("edge_no_tx_err", n_txerr, e0);

      // Stray done in IDLE.
      n0 = n_start;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_start", n_start, n0);

      // Reset 5 cycles into WAIT, then a late done tick.
      send(2, 1'b1, 8'h99, 1'b1);
      wait_start(50, "rstw_start");
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rstw");
      reset = 1'b1;
      n0 = n_start; e0 = n_txerr;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_done_busy", busy, 0);
      chk("late_done_start", n_start, n0);
      chk("late_done_tx_err", n_txerr, e0);

      // Requests pending during reset: nothing ready, requester 0 first after release.
      auto_done = 1'b1;
      reset = 1'b0;
      send(3, 1'b1, 8'hC3, 1'b0);
      send(0, 1'b1, 8'h0C, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_ready_zero", req_ready, 4'b0000);
      chk("rst_valid_seen", req_valid, 4'b1001);
      exp_q.push_back({2'd0, 8'h0C});
      exp_q.push_back({2'd3, 8'hC3});
      reset = 1'b1;
      wait_drain(300, "post_rst_drain");

      chk("sb_empty", exp_q.size(), 0);
      chk("tx_err_total", n_txerr, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
